// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-cycle logic/add/shift ops, radix-2 Booth multiply and
// non-restoring divide behind a start/busy/done handshake with a 2*WIDTH result.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic [12:0]        op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c,
  output logic               dz,
  output logic               bad_op
);

  localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_DFIX = 3'd3, S_DONE = 3'd4;

  localparam logic [12:0] OP_AND  = 13'h0001, OP_OR   = 13'h0002, OP_ADD  = 13'h0004;
  localparam logic [12:0] OP_SUB  = 13'h0008, OP_MUL  = 13'h0010, OP_DIV  = 13'h0020;
  localparam logic [12:0] OP_SHR  = 13'h0040, OP_SHRA = 13'h0080, OP_SHL  = 13'h0100;
  localparam logic [12:0] OP_ROR  = 13'h0200, OP_ROL  = 13'h0400, OP_NEG  = 13'h0800;
  localparam logic [12:0] OP_NOT  = 13'h1000;

  logic [2:0]         state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;      // Booth high half / signed partial remainder
  logic [WIDTH-1:0]   q_q, q_d;          // multiplier / quotient shift register
  logic [WIDTH-1:0]   m_q, m_d;          // multiplicand / divisor magnitude
  logic               qm1_q, qm1_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               dz_q, dz_d, bad_q, bad_d;

  logic               op_bad, last_iter;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rot_r, rot_l, alu_res;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_fix, quot_s, rem_s;
  logic [WIDTH:0]     booth_sum, booth_acc, div_shift, div_r;
  logic [WIDTH-1:0]   booth_q;

  assign op_bad    = (op == '0) || ((op & (op - 13'd1)) != '0);
  assign last_iter = (cnt_q == SHW'(WIDTH - 1));
  assign amt       = b[SHW-1:0];
  assign rot_r     = {a, a} >> amt;
  assign rot_l     = {a, a} << amt;
  assign a_abs     = a[WIDTH-1] ? -a : a;
  assign b_abs     = b[WIDTH-1] ? -b : b;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
      OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
      OP_SUB:  alu_res = {{WIDTH{1'b0}}, a - b};
      OP_SHR:  alu_res = {{WIDTH{1'b0}}, a >> amt};
      OP_SHRA: alu_res = {{WIDTH{1'b0}}, $unsigned($signed(a) >>> amt)};
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, a << amt};
      OP_ROR:  alu_res = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
      OP_ROL:  alu_res = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
      OP_NEG:  alu_res = {{WIDTH{1'b0}}, -a};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a};
      default: alu_res = '0;
    endcase
  end

  // Booth step: add/sub the sign-extended multiplicand, then arithmetic shift right.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
  end

  // Non-restoring step on magnitudes: subtract while the remainder is non-negative, else add.
  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign div_r     = acc_q[WIDTH] ? div_shift + {1'b0, m_q} : div_shift - {1'b0, m_q};
  assign rem_fix   = acc_q[WIDTH] ? acc_q[WIDTH-1:0] + m_q : acc_q[WIDTH-1:0];
  assign quot_s    = qneg_q ? -q_q : q_q;
  assign rem_s     = rneg_q ? -rem_fix : rem_fix;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    c_d     = c_q;
    dz_d    = dz_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          cnt_d = '0;
          if (op_bad) begin
            c_d = '0; dz_d = 1'b0; bad_d = 1'b1; state_d = S_DONE;
          end else if (op == OP_MUL) begin
            acc_d = '0; q_d = b; m_d = a; qm1_d = 1'b0; state_d = S_MUL;
          end else if (op == OP_DIV && b == '0) begin
            c_d = {a, {WIDTH{1'b1}}}; dz_d = 1'b1; bad_d = 1'b0; state_d = S_DONE;
          end else if (op == OP_DIV) begin
            acc_d  = '0; q_d = a_abs; m_d = b_abs;
            qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d = a[WIDTH-1];
            state_d = S_DIV;
          end else begin
            c_d = alu_res; dz_d = 1'b0; bad_d = 1'b0; state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = booth_acc;
        q_d   = booth_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          c_d = {booth_acc[WIDTH-1:0], booth_q}; dz_d = 1'b0; bad_d = 1'b0; state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_r;
        q_d   = {q_q[WIDTH-2:0], ~div_r[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = S_DFIX;
      end
      S_DFIX: begin
        c_d = {rem_s, quot_s}; dz_d = 1'b0; bad_d = 1'b0; state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      bad_q   <= bad_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_DFIX);
  assign done   = (state_q == S_DONE);
  assign c      = c_q;
  assign dz     = dz_q;
  assign bad_op = bad_q;

endmodule
